shift_register: RTL and testbench

An 8-bit (parameterisable) universal shift register with synchronous parallel load, logical shifts with serial inputs, rotates and arithmetic shift. It is a datapath leaf block, used as the serial/parallel conversion stage of the I2C byte path. It is fully synchronous to one clock, and mode is selected by a 3-bit code every cycle.

---
 rtl/shift_register_pkg.sv | 17 +
 rtl/shift_register_next.sv | 36 +++
 rtl/shift_register.sv | 37 +++
 tb/tb_shift_register.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// Shared types and constants for the universal shift register.
package shift_register_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [2:0] {
      LOAD = 3'b000,
      SHL  = 3'b001,
      SHR  = 3'b010,
      HOLD = 3'b011,
      ROL  = 3'b100,
      ROR  = 3'b101,
      ASR  = 3'b110,
      RSVD = 3'b111
   } mode_t;

endpackage

// File: rtl/shift_register_next.sv
// Combinational next-state function of the universal shift register.
// Rotate modes are compiled only when SHIFT_REGISTER_ROTATE_EN is defined.
module shift_register_next
   import shift_register_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic [2:0]       s,
   input  logic             msb_in,
   input  logic             lsb_in,
   output logic [WIDTH-1:0] q_next
);

   mode_t mode;

   assign mode = mode_t'(s);

   // Reserved, rotate codes in the plain build and unknown codes all hold.
   always_comb begin
      q_next = q;
      case (mode)
         LOAD:    q_next = d;
         SHL:     q_next = {q[WIDTH-2:0], lsb_in};
         SHR:     q_next = {msb_in, q[WIDTH-1:1]};
         ASR:     q_next = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef SHIFT_REGISTER_ROTATE_EN
         ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         ROR:     q_next = {q[0], q[WIDTH-1:1]};
`endif
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/shift_register.sv
// Universal shift register: state register with synchronous Clear priority.
// Optional rotate modes: define SHIFT_REGISTER_ROTATE_EN.
module shift_register
   import shift_register_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   output logic [WIDTH-1:0] Q,
   input  logic             Clock,
   input  logic             Clear,
   input  logic [WIDTH-1:0] D,
   input  logic [2:0]       S,
   input  logic             MSBIn,
   input  logic             LSBIn
);

   logic [WIDTH-1:0] q_next;

   shift_register_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .q      (Q),
      .d      (D),
      .s      (S),
      .msb_in (MSBIn),
      .lsb_in (LSBIn),
      .q_next (q_next)
   );

   always_ff @(posedge Clock) begin
      if (Clear)
         Q <= '0;
      else
         Q <= q_next;
   end

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register: arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed literal results.
module tb_shift_register;

   localparam int W = 8;
   localparam int M = 1 << W;

   logic [W-1:0] Q;
   logic         Clock;
   logic         Clear;
   logic [W-1:0] D;
   logic [2:0]   S;
   logic         MSBIn;
   logic         LSBIn;

   int compared   = 0;
   int mismatched = 0;
   int expv       = 0;
   bit valid      = 0;

`ifdef SHIFT_REGISTER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   shift_register #(.WIDTH(W)) dut (
      .Q     (Q),
      .Clock (Clock),
      .Clear (Clear),
      .D     (D),
      .S     (S),
      .MSBIn (MSBIn),
      .LSBIn (LSBIn)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic int model(input int q, input int s, input int d,
                                input int msb, input int lsb);
      case (s)
         0: return d;
         1: return (q * 2 + lsb) % M;
         2: return q / 2 + msb * (M / 2);
         4: return ROT ? (q * 2 + q / (M / 2)) % M : q;
         5: return ROT ? q / 2 + (q % 2) * (M / 2) : q;
         6: return q / 2 + ((q >= M / 2) ? M / 2 : 0);
         default: return q;
      endcase
   endfunction

   always @(posedge Clock) begin
      if (Clear === 1'b1) begin
         expv  = 0;
         valid = 1'b1;
      end else if (valid) begin
         expv = model(expv, int'(S), int'(D), int'(MSBIn), int'(LSBIn));
      end
   end

   always @(negedge Clock) begin
      if (valid) begin
         compared++;
         if (Q !== W'(expv)) begin
            mismatched++;
            $display("FAIL model t=%0t Q=%h expected=%h", $time, Q, W'(expv));
         end
      end
   end

   task automatic step(input logic clr, input logic [2:0] s, input logic [W-1:0] d,
                       input logic msb, input logic lsb);
      @(negedge Clock);
      Clear = clr;
      S     = s;
      D     = d;
      MSBIn = msb;
      LSBIn = lsb;
      @(posedge Clock);
      #1;
   endtask

   task automatic expect_q(input string name, input logic [W-1:0] want);
      compared++;
      if (Q !== want) begin
         mismatched++;
         $display("FAIL %s Q=%h expected=%h", name, Q, want);
      end
   endtask

   initial begin
      Clear = 1'b0; S = 3'b011; D = '0; MSBIn = 1'b0; LSBIn = 1'b0;

      step(1, 3'b000, 8'hFF, 1, 1);  expect_q("reset_load", 8'h00);
      step(1, 3'b001, 8'h5A, 1, 1);  expect_q("reset_shl", 8'h00);
      step(1, 3'bxxx, 8'hxx, 1, 1);  expect_q("reset_x", 8'h00);

      step(0, 3'b000, 8'hAA, 1, 1);  expect_q("load_aa", 8'hAA);
      step(0, 3'b011, 8'h00, 1, 1);
      step(0, 3'b011, 8'h33, 0, 1);
      step(0, 3'b011, 8'hFF, 1, 0);  expect_q("hold3", 8'hAA);

      step(0, 3'b001, 8'hFF, 1, 0);  expect_q("shl0_1", 8'h54);
      step(0, 3'b001, 8'hFF, 1, 0);  expect_q("shl0_2", 8'hA8);
      step(0, 3'b000, 8'hAA, 0, 0);
      step(0, 3'b001, 8'h00, 0, 1);  expect_q("shl1", 8'h55);

      step(0, 3'b000, 8'hAA, 0, 0);
      step(0, 3'b010, 8'h00, 1, 0);  expect_q("shr1_1", 8'hD5);
      step(0, 3'b010, 8'h00, 1, 0);  expect_q("shr1_2", 8'hEA);

      step(0, 3'b000, 8'hF0, 1, 1);
      step(0, 3'b110, 8'h00, 0, 1);  expect_q("asr_1", 8'hF8);
      step(0, 3'b110, 8'h00, 0, 1);  expect_q("asr_2", 8'hFC);
      step(0, 3'b000, 8'h70, 0, 0);
      step(0, 3'b110, 8'h00, 1, 1);  expect_q("asr_pos", 8'h38);

      step(0, 3'b000, 8'h81, 0, 0);
      step(0, 3'b100, 8'h00, 1, 1);  expect_q("rol", ROT ? 8'h03 : 8'h81);
      step(0, 3'b000, 8'h81, 0, 0);
      step(0, 3'b101, 8'h00, 1, 1);  expect_q("ror", ROT ? 8'hC0 : 8'h81);
      step(0, 3'b000, 8'h81, 0, 0);
      step(0, 3'b100, 8'h00, 0, 0);
      step(1, 3'b100, 8'hFF, 1, 1);  expect_q("clear_mid_rot", 8'h00);
      step(0, 3'b101, 8'h00, 1, 1);  expect_q("rot_from_zero", 8'h00);

      step(0, 3'b000, 8'h3C, 0, 0);
      step(0, 3'b111, 8'hFF, 1, 1);  expect_q("rsvd_hold", 8'h3C);

      // eight SHL edges leave the last eight LSBIn values, newest at bit 0
      for (int i = 0; i < 8; i++) begin
         logic [7:0] pat;
         pat = 8'b1011_0010;
         step(0, 3'b001, 8'hFF, 1, pat[7 - i]);
      end
      expect_q("shl_fill", 8'hB2);

      for (int i = 0; i < 60; i++)
         step(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
              8'($urandom), 1'($urandom), 1'($urandom));

      @(negedge Clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
